alu_issue_ctrl: RTL and testbench

//  Sequences one instruction at a time into the combinational MASTER_ALU datapath.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_issue_ctrl_cond_eval.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, condition-code, flag-bit and FSM-state definitions shared by the ALU issue controller.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_ORR = 4'h4, OP_EOR = 4'h5, OP_MOVN = 4'h6, OP_MOV = 4'h7;
  localparam logic [3:0] OP_LSL = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_CMP = 4'hB;
  localparam logic [3:0] CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3;
  localparam logic [3:0] CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7;
  localparam logic [3:0] CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB;
  localparam logic [3:0] CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF;
  localparam int FL_N = 3, FL_Z = 2, FL_C = 1, FL_V = 0;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;
endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// cond_eval: ARM condition-code check of a 4-bit cond against NZCV.
// Odd codes are the negation of the even code below them (AL/NV included).
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v, w_base;
  assign w_n = i_nzcv[FL_N];
  assign w_z = i_nzcv[FL_Z];
  assign w_c = i_nzcv[FL_C];
  assign w_v = i_nzcv[FL_V];
  always_comb begin
    w_base = 1'b1;
    case (i_cond[3:1])
      3'd0: w_base = w_z;
      3'd1: w_base = w_c;
      3'd2: w_base = w_n;
      3'd3: w_base = w_v;
      3'd4: w_base = w_c & ~w_z;
      3'd5: w_base = w_n == w_v;
      3'd6: w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
  end
  assign o_pass = w_base ^ i_cond[0];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one conditional instruction at a time to the ALU,
// waits its latency, captures result/flags and offers the result for writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int RD_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [3:0]      i_in_opcode,
  input  logic [3:0]      i_in_cond,
  input  logic            i_in_s,
  input  logic [RD_W-1:0] i_in_rd,
  input  logic [31:0]     i_in_op1,
  input  logic [31:0]     i_in_op2,
  input  logic [15:0]     i_in_iv,
  output logic [31:0]     o_alu_reg1,
  output logic [31:0]     o_alu_reg2,
  output logic [15:0]     o_alu_iv,
  output logic [3:0]      o_alu_opcode,
  output logic            o_alu_s,
  output logic [3:0]      o_alu_flag,
  input  logic [31:0]     i_alu_result,
  input  logic [3:0]      i_alu_new_flag,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [RD_W-1:0] o_wb_rd,
  output logic [31:0]     o_wb_data,
  output logic [3:0]      o_flags,
  output logic            o_illegal
);
  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [RD_W-1:0] r_rd, r_wb_rd;
  logic [31:0]     r_alu_reg1, r_alu_reg2, r_wb_data;
  logic [15:0]     r_alu_iv;
  logic [3:0]      r_alu_opcode, r_flags;
  logic            r_alu_s, r_wb_valid, r_illegal;
  logic            w_pass, w_reserved, w_s_eff;

  cond_eval u_cond (.i_cond(i_in_cond), .i_nzcv(r_flags), .o_pass(w_pass));

  assign w_reserved = i_in_opcode[3:2] == 2'b11;
  // CMP exists only for its flags; the MOV forms must never disturb them
  assign w_s_eff = (i_in_opcode == OP_CMP) |
                   (i_in_s & (i_in_opcode != OP_MOVN) & (i_in_opcode != OP_MOV));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd         <= '0;
      r_alu_reg1   <= '0;
      r_alu_reg2   <= '0;
      r_alu_iv     <= '0;
      r_alu_opcode <= '0;
      r_alu_s      <= 1'b0;
      r_flags      <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_illegal    <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: if (i_in_valid && w_pass) begin
          if (w_reserved) r_illegal <= 1'b1;
          else begin
            r_alu_reg1   <= i_in_op1;
            r_alu_reg2   <= i_in_op2;
            r_alu_iv     <= i_in_iv;
            r_alu_opcode <= i_in_opcode;
            r_alu_s      <= w_s_eff;
            r_rd         <= i_in_rd;
            r_cnt        <= i_in_opcode == OP_MUL ? 8'(MUL_LAT) : 8'(ALU_LAT);
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            if (r_alu_s) r_flags <= i_alu_new_flag;
            if (r_alu_opcode == OP_CMP) r_state <= S_IDLE;
            else begin
              r_wb_data  <= i_alu_result;
              r_wb_rd    <= r_rd;
              r_wb_valid <= 1'b1;
              r_state    <= S_WB;
            end
          end
        end
        S_WB: if (i_wb_ready) begin
          r_wb_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready   = r_state == S_IDLE;
  assign o_alu_reg1   = r_alu_reg1;
  assign o_alu_reg2   = r_alu_reg2;
  assign o_alu_iv     = r_alu_iv;
  assign o_alu_opcode = r_alu_opcode;
  assign o_alu_s      = r_alu_s;
  assign o_alu_flag   = r_flags;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_rd      = r_wb_rd;
  assign o_wb_data    = r_wb_data;
  assign o_flags      = r_flags;
  assign o_illegal    = r_illegal;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions against a per-instruction reference model,
// with a behavioural ALU standing in for the parent's datapath.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_in_valid = 1'b0, i_in_s = 1'b0, i_wb_ready = 1'b0;
  logic [3:0]  i_in_opcode = '0, i_in_cond = '0, i_in_rd = '0;
  logic [31:0] i_in_op1 = '0, i_in_op2 = '0;
  logic [15:0] i_in_iv = '0;
  logic        o_in_ready, o_alu_s, o_wb_valid, o_illegal;
  logic [31:0] o_alu_reg1, o_alu_reg2, o_wb_data, i_alu_result;
  logic [15:0] o_alu_iv;
  logic [3:0]  o_alu_opcode, o_alu_flag, i_alu_new_flag, o_wb_rd, o_flags;
  logic [3:0]  mflags = '0;
  int          n_chk = 0, n_fail = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_opcode(i_in_opcode), .i_in_cond(i_in_cond), .i_in_s(i_in_s), .i_in_rd(i_in_rd),
    .i_in_op1(i_in_op1), .i_in_op2(i_in_op2), .i_in_iv(i_in_iv),
    .o_alu_reg1(o_alu_reg1), .o_alu_reg2(o_alu_reg2), .o_alu_iv(o_alu_iv),
    .o_alu_opcode(o_alu_opcode), .o_alu_s(o_alu_s), .o_alu_flag(o_alu_flag),
    .i_alu_result(i_alu_result), .i_alu_new_flag(i_alu_new_flag),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_flags(o_flags), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [15:0] iv, input logic [3:0] f);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    c = f[1];
    v = f[0];
    r = '0;
    w = '0;
    case (op)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h1, 4'hB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = w[31:0];
        c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h2: r = a * b;
      4'h3: r = a & b;
      4'h4: r = a | b;
      4'h5: r = a ^ b;
      4'h6: r = {16'h0, iv};
      4'h7: r = b;
      4'h8: r = a << b[4:0];
      4'h9: r = a >> b[4:0];
      4'hA: r = $signed(a) >>> b[4:0];
      default: r = '0;
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  always_comb {i_alu_new_flag, i_alu_result} = alu_fn(o_alu_opcode, o_alu_reg1, o_alu_reg2, o_alu_iv, o_alu_flag);

  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input logic [3:0] op, input logic [3:0] cc, input logic s, input logic [3:0] rd,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv, input int dly);
    bit pass, rsv, se;
    int lat;
    logic [35:0] r;
    pass = cond_ok(cc, mflags);
    rsv  = op[3:2] == 2'b11;
    se   = (op == 4'hB) || (s && op != 4'h6 && op != 4'h7);
    lat  = (op == 4'h2) ? 3 : 1;
    r    = alu_fn(op, a, b, iv, mflags);
    i_in_opcode = op; i_in_cond = cc; i_in_s = s; i_in_rd = rd;
    i_in_op1 = a; i_in_op2 = b; i_in_iv = iv;
    i_in_valid = 1'b1;
    i_wb_ready = 1'b0;
    @(negedge clk);
    i_in_valid = 1'b0;
    if (!pass || rsv) begin
      chk("illegal", o_illegal, pass && rsv);
      chk("rdy_drop", o_in_ready, 1);
      chk("wbv_drop", o_wb_valid, 0);
      chk("flags_drop", o_flags, mflags);
      @(negedge clk);
      chk("illegal_clr", o_illegal, 0);
    end else begin
      chk("rdy_busy", o_in_ready, 0);
      chk("alu_op", o_alu_opcode, op);
      chk("alu_s", o_alu_s, se);
      chk("wbv_early", o_wb_valid, 0);
      repeat (lat - 1) begin
        @(negedge clk);
        chk("wbv_early", o_wb_valid, 0);
        chk("rdy_busy", o_in_ready, 0);
      end
      @(negedge clk);
      if (se) mflags = r[35:32];
      chk("flags", o_flags, mflags);
      if (op == 4'hB) begin
        chk("cmp_nowb", o_wb_valid, 0);
        chk("rdy_cmp", o_in_ready, 1);
      end else begin
        chk("wbv", o_wb_valid, 1);
        chk("wbd", o_wb_data, r[31:0]);
        chk("wbrd", o_wb_rd, rd);
        chk("rdy_wb", o_in_ready, 0);
        repeat (dly) begin
          @(negedge clk);
          chk("wbv_hold", o_wb_valid, 1);
          chk("wbd_hold", o_wb_data, r[31:0]);
          chk("rdy_hold", o_in_ready, 0);
        end
        i_wb_ready = 1'b1;
        @(negedge clk);
        i_wb_ready = 1'b0;
        chk("wbv_done", o_wb_valid, 0);
        chk("rdy_done", o_in_ready, 1);
      end
    end
  endtask

  initial begin
    logic [3:0] op, cc, rd;
    logic [31:0] a, b;
    #2;
    chk("rst_rdy", o_in_ready, 1);
    chk("rst_flags", o_flags, 0);
    chk("rst_wbv", o_wb_valid, 0);
    chk("rst_ill", o_illegal, 0);
    chk("rst_reg1", o_alu_reg1, 0);
    chk("rst_op", o_alu_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'h0, 4'hE, 1'b0, 4'd3, 32'd5, 32'd7, 16'h0, 0);
    issue(4'h2, 4'hE, 1'b1, 4'd4, 32'hFFFF_FFFD, 32'd4, 16'h0, 0);
    chk("mul_nz", o_flags[3:2], 2'b10);
    issue(4'hB, 4'hE, 1'b0, 4'd0, 32'd9, 32'd9, 16'h0, 0);
    chk("cmp_z", o_flags[2], 1);
    issue(4'h0, 4'h0, 1'b0, 4'd5, 32'd1, 32'd2, 16'h0, 0);
    issue(4'hB, 4'hE, 1'b0, 4'd0, 32'd9, 32'd9, 16'h0, 0);
    issue(4'h0, 4'h1, 1'b0, 4'd6, 32'd1, 32'd2, 16'h0, 0);
    issue(4'hD, 4'hE, 1'b1, 4'd7, 32'd1, 32'd2, 16'h0, 0);
    issue(4'h0, 4'hE, 1'b0, 4'd8, 32'd100, 32'd23, 16'h0, 5);
    issue(4'h6, 4'hE, 1'b1, 4'd9, 32'd0, 32'd0, 16'hBEEF, 1);
    issue(4'h7, 4'hE, 1'b1, 4'd10, 32'd0, 32'd0, 16'h0, 0);
    // reset in the middle of a MUL: the result must vanish and flags clear
    i_in_opcode = 4'h2; i_in_cond = 4'hE; i_in_s = 1'b1; i_in_rd = 4'd2;
    i_in_op1 = 32'd6; i_in_op2 = 32'd7; i_in_valid = 1'b1;
    @(negedge clk);
    i_in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdy", o_in_ready, 1);
    chk("arst_flags", o_flags, 0);
    chk("arst_wbv", o_wb_valid, 0);
    mflags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("arst_nowb", o_wb_valid, 0);
      chk("arst_rdy2", o_in_ready, 1);
    end
    for (int k = 0; k < 200; k++) begin
      op = 4'($urandom_range(0, 15));
      cc = op[3:2] == 2'b11 ? 4'hE : 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      a  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom();
      b  = $urandom_range(0, 3) == 0 ? a : $urandom();
      issue(op, cc, 1'($urandom_range(0, 1)), rd, a, b, 16'($urandom()), int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
